// File: rtl/ks_pkg.sv
// Shared definitions for the multi-word Kogge-Stone add/subtract sequencer.
package ks_pkg;

  // Width of one slice, fixed by the prefix adder datapath.
  localparam int SLICE_W = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for a slice counter; at least one bit so WORDS=1 still has a register.
  function automatic int clog2(input int words);
    int w;
    w = 1;
    while ((1 << w) < words) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/ks_add16_cin.sv
// 16-bit Kogge-Stone adder with carry-in, purely combinational.
// The carry-in is treated as an extra generate bit at position -1 (vector index 0)
// ahead of the operand bits, so the prefix tree yields every carry including cout.
module ks_add16_cin
  import ks_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  // Extended vector: index 0 is the carry-in, index k+1 is operand bit k.
  localparam int N  = SLICE_W + 1;
  localparam int LV = 5;  // ceil(log2(17)) prefix levels

  logic [N-1:0] g_sq;
  logic [N-1:0] p_sq;
  logic [N-1:0] g_pre;
  logic [N-1:0] p_pre;

  // Square cells: bitwise generate/propagate; the carry-in position never propagates.
  assign g_sq[0] = cin_i;
  assign p_sq[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_square
      assign g_sq[gi+1] = a_i[gi] & b_i[gi];
      assign p_sq[gi+1] = a_i[gi] ^ b_i[gi];
    end
  endgenerate

  // Prefix tree: each level applies the circle cell (g,p) across distance 2^lv.
  // Positions whose span already reaches index 0 behave as triangle cells: their
  // group propagate is 0 because the carry-in position never propagates.
  always_comb begin
    g_pre = g_sq;
    p_pre = p_sq;
    for (int lv = 0; lv < LV; lv++) begin
      g_pre = g_pre | (p_pre & (g_pre << (1 << lv)));
      p_pre = p_pre & (p_pre << (1 << lv));
    end
  end

  // Carry into operand bit k is the group generate over [-1 .. k-1].
  assign sum_o  = p_sq[N-1:1] ^ g_pre[N-2:0];
  assign cout_o = g_pre[N-1];

endmodule

// File: rtl/ks_multiword_add_seq.sv
// Multi-word add/subtract sequencer: streams WORDS 16-bit slices through a single
// Kogge-Stone slice adder, chaining the registered carry between slices.
module ks_multiword_add_seq
  import ks_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDS*SLICE_W-1:0]   in_a,
  input  logic [WORDS*SLICE_W-1:0]   in_b,
  input  logic                       in_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORDS*SLICE_W-1:0]   out_sum,
  output logic                       out_cout,
  output logic                       out_ovf,
  output logic                       busy
);

  localparam int SW = SLICE_W;
  localparam int TW = WORDS * SLICE_W;
  localparam int IW = clog2(WORDS);

  state_e          state_q;
  logic [TW-1:0]   op_a_q;
  logic [TW-1:0]   op_b_q;
  logic [TW-1:0]   sum_q;
  logic [TW-1:0]   sum_d;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            out_cout_q;
  logic            out_ovf_q;
  logic            busy_q;

  logic [SW-1:0]   slice_a;
  logic [SW-1:0]   slice_b;
  logic [SW-1:0]   slice_s;
  logic            slice_cout;
  logic            last_slice;

  assign slice_a    = op_a_q[int'(idx_q)*SW +: SW];
  assign slice_b    = op_b_q[int'(idx_q)*SW +: SW];
  assign last_slice = (int'(idx_q) == WORDS - 1);

  ks_add16_cin u_add (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_s),
    .cout_o (slice_cout)
  );

  // Result register with the current slice merged in at position idx.
  always_comb begin
    sum_d = sum_q;
    sum_d[int'(idx_q)*SW +: SW] = slice_s;
  end

  // Sequencer FSM: capture, stream slices, then hold the result until consumed.
  // Flags are formed in the first DONE cycle from the registered carry and sum,
  // keeping the prefix-adder path out of the flag logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_a_q     <= in_a;
            op_b_q     <= in_sub ? ~in_b : in_b;
            carry_q    <= in_sub;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (last_slice) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_cout_q  <= carry_q;
            out_ovf_q   <= (op_a_q[TW-1] == op_b_q[TW-1]) && (sum_q[TW-1] != op_a_q[TW-1]);
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ks_multiword_add_seq.sv
// Scoreboard bench for ks_multiword_add_seq: directed and random traffic on a
// WORDS=4 instance, random traffic on WORDS=1 and WORDS=16 instances.
module tb_ks_multiword_add_seq;

  typedef struct packed {
    logic [255:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_r = 1'b0;
  bit   rand_done [2];
  bit   rand_bp = 1'b0;

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic on the w*16-bit operands.
  function automatic exp_t ref_model(input int w, input logic [255:0] a,
                                     input logic [255:0] b, input logic sub);
    exp_t r;
    logic [256:0] full;
    logic [255:0] mask;
    int n;
    n = 16 * w;
    mask = '1;
    if (n < 256) mask = mask >> (256 - n);
    a = a & mask;
    b = b & mask;
    full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r.sum = full[255:0] & mask;
    r.cout = sub ? (a >= b) : full[n];
    if (sub) r.ovf = (a[n-1] != b[n-1]) && (r.sum[n-1] != a[n-1]);
    else     r.ovf = (a[n-1] == b[n-1]) && (r.sum[n-1] != a[n-1]);
    return r;
  endfunction

  function automatic exp_t mk(input logic [255:0] s, input logic c, input logic o);
    exp_t r;
    r.sum = s;
    r.cout = c;
    r.ovf = o;
    return r;
  endfunction

  // ---------------- WORDS=4 instance ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        busy;

  exp_t q4[$];
  exp_t m4;

  ks_multiword_add_seq #(.WORDS(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected got sum=%h required no result", out_sum);
      end else begin
        m4 = q4.pop_front();
        if (out_sum !== m4.sum[63:0] || out_cout !== m4.cout || out_ovf !== m4.ovf) begin
          errors++;
          $display("FAIL w4_result got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                   out_sum, out_cout, out_ovf, m4.sum[63:0], m4.cout, m4.ovf);
        end else begin
          $display("txn w4 sum=%h cout=%b ovf=%b", out_sum, out_cout, out_ovf);
        end
      end
    end
  end

  // Issue one request and queue its expected result; returns 1 time unit after the accept edge.
  task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic sub, input exp_t e);
    int n;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL w4_accept_timeout got in_ready=0 required 1");
    end else begin
      q4.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // ---------------- WORDS=1 and WORDS=16 instances ----------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rand
      localparam int W = (gi == 0) ? 1 : 16;
      logic            r_in_valid;
      logic            r_in_ready;
      logic [16*W-1:0] r_in_a;
      logic [16*W-1:0] r_in_b;
      logic            r_in_sub;
      logic            r_out_valid;
      logic            r_out_ready;
      logic [16*W-1:0] r_out_sum;
      logic            r_out_cout;
      logic            r_out_ovf;
      logic            r_busy;
      exp_t            q[$];
      exp_t            m;

      ks_multiword_add_seq #(.WORDS(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n_r),
        .in_valid  (r_in_valid),
        .in_ready  (r_in_ready),
        .in_a      (r_in_a),
        .in_b      (r_in_b),
        .in_sub    (r_in_sub),
        .out_valid (r_out_valid),
        .out_ready (r_out_ready),
        .out_sum   (r_out_sum),
        .out_cout  (r_out_cout),
        .out_ovf   (r_out_ovf),
        .busy      (r_busy)
      );

      always @(posedge clk) begin
        #1;
        r_out_ready = ($urandom_range(0, 3) != 0);
      end

      always @(negedge clk) begin
        if (rst_n_r && r_out_valid && r_out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL w%0d_unexpected got sum=%h required no result", W, r_out_sum);
          end else begin
            m = q.pop_front();
            if (r_out_sum !== m.sum[16*W-1:0] || r_out_cout !== m.cout || r_out_ovf !== m.ovf) begin
              errors++;
              $display("FAIL w%0d_result got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                       W, r_out_sum, r_out_cout, r_out_ovf, m.sum[16*W-1:0], m.cout, m.ovf);
            end else begin
              $display("txn w%0d sum=%h cout=%b ovf=%b", W, r_out_sum, r_out_cout, r_out_ovf);
            end
          end
        end
      end

      initial begin
        logic [255:0] a;
        logic [255:0] b;
        logic s;
        int n;
        r_in_valid = 1'b0;
        r_in_a = '0;
        r_in_b = '0;
        r_in_sub = 1'b0;
        r_out_ready = 1'b1;
        @(posedge rst_n_r);
        for (int t = 0; t < 40; t++) begin
          for (int k = 0; k < 8; k++) begin
            a[32*k +: 32] = $urandom;
            b[32*k +: 32] = $urandom;
          end
          s = 1'($urandom_range(0, 1));
          if (t % 5 == 0) begin
            a = '1;
            b = 256'd1;
          end
          @(negedge clk);
          r_in_a = a[16*W-1:0];
          r_in_b = b[16*W-1:0];
          r_in_sub = s;
          r_in_valid = 1'b1;
          n = 0;
          while (!r_in_ready && n < 200) begin
            @(negedge clk);
            n++;
          end
          if (!r_in_ready) begin
            checks++;
            errors++;
            $display("FAIL w%0d_accept_timeout got in_ready=0 required 1", W);
          end else begin
            q.push_back(ref_model(W, a, b, s));
          end
          @(posedge clk);
          #1 r_in_valid = 1'b0;
        end
        n = 0;
        while (q.size() != 0 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        if (q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL w%0d_drain got %0d pending required 0", W, q.size());
        end
        rand_done[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin
    #25 rst_n_r = 1'b1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence on WORDS=4 ----------------
  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic s;
    logic [63:0] snap_sum;
    logic snap_c;
    logic snap_o;
    int lat;
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 64'd0 ||
        out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b sum=%h c=%b o=%b required 1 0 0 0 0 0",
               in_ready, out_valid, busy, out_sum, out_cout, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: slice carry crossing, plus latency
    send4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, mk(256'h0000_0000_0001_0000, 1'b0, 1'b0));
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && lat == 0) lat = k;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL latency got %0d required 5", lat);
    end

    // Tests 2-4: full ripple, borrow, signed overflow
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk(256'h0, 1'b1, 1'b0));
    send4(64'h5, 64'h7, 1'b1, mk(256'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
    send4(64'h7, 64'h5, 1'b1, mk(256'h2, 1'b1, 1'b0));
    send4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk(256'h8000_0000_0000_0000, 1'b0, 1'b1));
    send4(64'h8000_0000_0000_0000, 64'h1, 1'b1, mk(256'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));

    // Test 5: backpressure in DONE
    n = 0;
    while (q4.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h0FED_CBA9_8765_4321;
    send4(a, b, 1'b0, ref_model(4, {192'd0, a}, {192'd0, b}, 1'b0));
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL bp_valid_timeout got out_valid=0 required 1");
    end
    snap_sum = out_sum;
    snap_c = out_cout;
    snap_o = out_ovf;
    in_a = ~a;
    in_b = 64'h1111_2222_3333_4444;
    in_sub = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== snap_sum ||
          out_cout !== snap_c || out_ovf !== snap_o) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b sum=%h required vld=1 rdy=0 sum=%h",
                 k, out_valid, in_ready, out_sum, snap_sum);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    q4.push_back(ref_model(4, {192'd0, in_a}, {192'd0, in_b}, in_sub));
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept got rdy=%b busy=%b required rdy=0 busy=1", in_ready, busy);
    end
    in_valid = 1'b0;
    n = 0;
    while (q4.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end

    // Test 6: reset while idx=2 with a live carry
    send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, mk(256'h0, 1'b1, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== 64'd0) begin
      errors++;
      $display("FAIL async_reset got vld=%b rdy=%b busy=%b sum=%h required 0 1 0 0",
               out_valid, in_ready, busy, out_sum);
    end
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send4(64'hFFFF, 64'h0, 1'b0, mk(256'hFFFF, 1'b0, 1'b0));

    // Random traffic with random backpressure
    rand_bp = 1'b1;
    for (int t = 0; t < 40; t++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      if (t % 7 == 0) b = ~a;
      send4(a, b, s, ref_model(4, {192'd0, a}, {192'd0, b}, s));
    end
    n = 0;
    while (q4.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL w4_drain got %0d pending required 0", q4.size());
    end
    @(posedge clk);
    #2 rand_bp = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (!(rand_done[0] && rand_done[1]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(rand_done[0] && rand_done[1])) begin
      checks++;
      errors++;
      $display("FAIL rand_blocks got done=%b%b required 11", rand_done[1], rand_done[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
